// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Produces forwarding selects, the load-use stall/bubble, the branch flush
// and the multi-cycle EXE hold, and counts stalled cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              exe_wreg,
    input  logic              exe_m2reg,
    input  logic [REG_AW-1:0] exe_rn,
    input  logic              exe_mc,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_rn,
    input  logic              wb_wreg,
    input  logic [REG_AW-1:0] wb_rn,
    input  logic              br_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              exe_hold,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned MC_W = $clog2(MC_LAT) + 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MC_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MC_W-1:0]   r_mc_left;
    logic [MC_W-1:0]   w_mc_left_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_hit_exe_a, w_hit_mem_a, w_hit_wb_a;
    logic w_hit_exe_b, w_hit_mem_b, w_hit_wb_b;
    logic w_raw_any;
    logic w_load_use;
    logic w_stall, w_bubble, w_flush, w_hold;
    logic [1:0] w_sel_a, w_sel_b;

    // Source/destination matches; register 0 never produces a hazard.
    always_comb begin
        w_hit_exe_a = exe_wreg & (exe_rn == id_rs) & (id_rs != '0) & id_use_rs;
        w_hit_mem_a = mem_wreg & (mem_rn == id_rs) & (id_rs != '0) & id_use_rs;
        w_hit_wb_a  = wb_wreg  & (wb_rn  == id_rs) & (id_rs != '0) & id_use_rs;
        w_hit_exe_b = exe_wreg & (exe_rn == id_rt) & (id_rt != '0) & id_use_rt;
        w_hit_mem_b = mem_wreg & (mem_rn == id_rt) & (id_rt != '0) & id_use_rt;
        w_hit_wb_b  = wb_wreg  & (wb_rn  == id_rt) & (id_rt != '0) & id_use_rt;
        w_raw_any   = w_hit_exe_a | w_hit_mem_a | w_hit_wb_a |
                      w_hit_exe_b | w_hit_mem_b | w_hit_wb_b;
        if (FWD_EN != 0) begin
            w_load_use = exe_m2reg & (w_hit_exe_a | w_hit_exe_b);
        end else begin
            w_load_use = w_raw_any;
        end
    end

    // Forwarding priority: youngest producer (EXE) wins over MEM, then WB.
    always_comb begin
        w_sel_a = 2'b00;
        w_sel_b = 2'b00;
        if (w_hit_exe_a)      w_sel_a = 2'b01;
        else if (w_hit_mem_a) w_sel_a = 2'b10;
        else if (w_hit_wb_a)  w_sel_a = 2'b11;
        if (w_hit_exe_b)      w_sel_b = 2'b01;
        else if (w_hit_mem_b) w_sel_b = 2'b10;
        else if (w_hit_wb_b)  w_sel_b = 2'b11;
    end

    // FSM state and remaining-hold counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_mc_left <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mc_left <= w_mc_left_nxt;
        end
    end

    // Next state and control outputs; the multi-cycle hold overrides everything else.
    always_comb begin
        w_state_nxt   = r_state;
        w_mc_left_nxt = r_mc_left;
        w_stall       = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_hold        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall  = w_load_use;
                w_bubble = w_load_use;
                w_flush  = br_taken & ~w_load_use;
                if (exe_mc && (MC_LAT > 1)) begin
                    w_state_nxt   = S_MC_BUSY;
                    w_mc_left_nxt = MC_W'(MC_LAT - 1);
                end
            end
            S_MC_BUSY: begin
                w_hold        = 1'b1;
                w_stall       = 1'b1;
                w_mc_left_nxt = r_mc_left - MC_W'(1);
                if (r_mc_left == MC_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mc_left_nxt = '0;
            end
        endcase
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Outputs are held low while reset is asserted; selects drop to regfile on any stall.
    always_comb begin
        stall     = Resetn & w_stall;
        bubble    = Resetn & w_bubble;
        flush     = Resetn & w_flush;
        exe_hold  = Resetn & w_hold;
        fwda      = 2'b00;
        fwdb      = 2'b00;
        if (Resetn && (FWD_EN != 0) && !w_stall) begin
            fwda = w_sel_a;
            fwdb = w_sel_b;
        end
        stall_cnt = r_stall_cnt;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one forwarding instance and one
// stall-only instance with a narrow counter for saturation.
module tb_pipe_hazard_ctrl;

    logic       Clock;
    logic       Resetn;
    logic [4:0] id_rs, id_rt, exe_rn, mem_rn, wb_rn;
    logic       id_use_rs, id_use_rt, exe_wreg, exe_m2reg, exe_mc;
    logic       mem_wreg, wb_wreg, br_taken;

    logic       s0, b0, f0, h0;
    logic [1:0] fa0, fb0;
    logic [15:0] cnt0;
    logic       s1, b1, f1, h1;
    logic [1:0] fa1, fb1;
    logic [1:0] cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MC_LAT(4), .CNT_W(16)) u_fwd (
        .Clock(Clock), .Resetn(Resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .exe_mc(exe_mc),
        .mem_wreg(mem_wreg), .mem_rn(mem_rn), .wb_wreg(wb_wreg), .wb_rn(wb_rn),
        .br_taken(br_taken),
        .stall(s0), .bubble(b0), .flush(f0), .exe_hold(h0),
        .fwda(fa0), .fwdb(fb0), .stall_cnt(cnt0)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MC_LAT(4), .CNT_W(2)) u_stl (
        .Clock(Clock), .Resetn(Resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .exe_mc(exe_mc),
        .mem_wreg(mem_wreg), .mem_rn(mem_rn), .wb_wreg(wb_wreg), .wb_rn(wb_rn),
        .br_taken(br_taken),
        .stall(s1), .bubble(b1), .flush(f1), .exe_hold(h1),
        .fwda(fa1), .fwdb(fb1), .stall_cnt(cnt1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; exe_rn = '0; mem_rn = '0; wb_rn = '0;
        id_use_rs = 0; id_use_rt = 0; exe_wreg = 0; exe_m2reg = 0; exe_mc = 0;
        mem_wreg = 0; wb_wreg = 0; br_taken = 0;
    endtask

    initial begin
        Resetn = 1'b0;
        clr();
        #2;
        chk("rst_stall", 32'(s0), 0);
        chk("rst_hold",  32'(h0), 0);
        chk("rst_cnt",   32'(cnt0), 0);
        tick();
        Resetn = 1'b1;

        // 1: load-use, then forward from MEM
        id_rs = 1; id_use_rs = 1; exe_wreg = 1; exe_m2reg = 1; exe_rn = 1;
        #1;
        chk("lu_stall",  32'(s0), 1);
        chk("lu_bubble", 32'(b0), 1);
        chk("lu_fwda",   32'(fa0), 0);
        tick();
        exe_wreg = 0; exe_m2reg = 0; mem_wreg = 1; mem_rn = 1;
        #1;
        chk("lu2_stall", 32'(s0), 0);
        chk("lu2_fwda",  32'(fa0), 2);
        chk("lu2_cnt",   32'(cnt0), 1);

        // 2: forwarding priority
        clr();
        exe_rn = 3; mem_rn = 3; wb_rn = 3; exe_wreg = 1; mem_wreg = 1; wb_wreg = 1;
        id_rs = 3; id_rt = 3; id_use_rs = 1; id_use_rt = 1;
        #1;
        chk("pri_exe_a", 32'(fa0), 1);
        chk("pri_exe_b", 32'(fb0), 1);
        exe_wreg = 0;
        #1;
        chk("pri_mem_a", 32'(fa0), 2);
        chk("pri_mem_b", 32'(fb0), 2);
        mem_wreg = 0;
        #1;
        chk("pri_wb_a",  32'(fa0), 3);
        chk("pri_wb_b",  32'(fb0), 3);
        chk("pri_stall", 32'(s0), 0);

        // 3: register 0 is never a hazard
        clr();
        exe_wreg = 1; exe_rn = 0; id_rs = 0; id_use_rs = 1; exe_m2reg = 1;
        #1;
        chk("r0_stall", 32'(s0), 0);
        chk("r0_fwda",  32'(fa0), 0);
        tick();

        // 4: multi-cycle hold for MC_LAT-1 = 3 cycles
        clr();
        exe_mc = 1;
        #1;
        chk("mc_idle_hold", 32'(h0), 0);
        tick();
        exe_mc = 0;
        #1;
        chk("mc1_hold",   32'(h0), 1);
        chk("mc1_stall",  32'(s0), 1);
        chk("mc1_bubble", 32'(b0), 0);
        tick();
        exe_mc = 1; br_taken = 1;
        #1;
        chk("mc2_hold",  32'(h0), 1);
        chk("mc2_flush", 32'(f0), 0);
        tick();
        exe_mc = 0; br_taken = 0;
        #1;
        chk("mc3_hold", 32'(h0), 1);
        tick();
        chk("mc_end_hold",  32'(h0), 0);
        chk("mc_end_stall", 32'(s0), 0);
        chk("mc_end_cnt",   32'(cnt0), 4);
        tick();
        chk("mc_ignored",   32'(h0), 0);

        // 5: branch during load-use does not flush
        clr();
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 2; id_rt = 2; id_use_rt = 1; br_taken = 1;
        #1;
        chk("br_lu_stall", 32'(s0), 1);
        chk("br_lu_flush", 32'(f0), 0);
        chk("br_lu_fwdb",  32'(fb0), 0);
        tick();
        clr();
        br_taken = 1;
        #1;
        chk("br_flush", 32'(f0), 1);
        chk("br_cnt",   32'(cnt0), 5);
        tick();

        // reset asserted mid-hold
        clr();
        exe_mc = 1;
        tick();
        exe_mc = 0; br_taken = 1; id_rs = 7; id_use_rs = 1; mem_wreg = 1; mem_rn = 7;
        #1;
        chk("pre_rst_hold", 32'(h0), 1);
        Resetn = 1'b0;
        #1;
        chk("mrst_hold",  32'(h0), 0);
        chk("mrst_stall", 32'(s0), 0);
        chk("mrst_flush", 32'(f0), 0);
        chk("mrst_fwda",  32'(fa0), 0);
        chk("mrst_cnt",   32'(cnt0), 0);
        tick();
        clr();
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        chk("rel_hold", 32'(h0), 0);
        chk("rel_stall", 32'(s0), 0);
        tick();
        chk("rel_cnt", 32'(cnt0), 0);

        // 6: stall-only mode stalls even on a WB hit; counter saturates
        wb_wreg = 1; wb_rn = 5; id_rt = 5; id_use_rt = 1;
        #1;
        chk("so_stall",  32'(s1), 1);
        chk("so_bubble", 32'(b1), 1);
        chk("so_fwdb",   32'(fb1), 0);
        chk("fw_wb_fwdb", 32'(fb0), 3);
        chk("fw_wb_stall", 32'(s0), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("so_cnt_sat", 32'(cnt1), 3);
        chk("fw_cnt",     32'(cnt0), 0);
        clr();
        exe_wreg = 1; exe_rn = 9; id_rs = 9; id_use_rs = 1;
        #1;
        chk("so_exe_stall", 32'(s1), 1);
        chk("so_exe_fwda",  32'(fa1), 0);
        chk("fw_exe_fwda",  32'(fa0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
